// File: rtl/irda_fir_rx_ctrl_if.sv
// Bus between the FIR flag detector / receive FIFO side and irda_fir_rx_ctrl.
//   master: detector-side driver (enable, strobe, flags, data bit, FIFO full)
//   slave : the receive controller (restart, byte/write strobe, frame status)
interface irda_fir_rx_ctrl_if;
  logic        fir_rx_en;
  logic        fir_rx8_enable;
  logic        pa_det;
  logic        sta_det;
  logic        sto_det;
  logic        break_det;
  logic        fd_data_bit;
  logic        fd_o;
  logic        rx_fifo_full;
  logic        fd_restart;
  logic [7:0]  rx_byte;
  logic        rx_byte_we;
  logic        rx_start;
  logic        rx_end;
  logic [3:0]  rx_status;
  logic [11:0] rx_byte_cnt;
  logic        rx_active;

  modport master (
    output fir_rx_en, fir_rx8_enable, pa_det, sta_det, sto_det, break_det,
           fd_data_bit, fd_o, rx_fifo_full,
    input  fd_restart, rx_byte, rx_byte_we, rx_start, rx_end, rx_status,
           rx_byte_cnt, rx_active
  );

  modport slave (
    input  fir_rx_en, fir_rx8_enable, pa_det, sta_det, sto_det, break_det,
           fd_data_bit, fd_o, rx_fifo_full,
    output fd_restart, rx_byte, rx_byte_we, rx_start, rx_end, rx_status,
           rx_byte_cnt, rx_active
  );
endinterface

// File: rtl/irda_fir_rx_ctrl.sv
// FIR (4 Mb/s, 4PPM) receive frame controller.
// Tracks hunt/preamble/data, restarts the flag detector, packs LSB-first
// data bits into bytes for the receive FIFO and reports per-frame status.
// Ports:
//   clk       : system clock
//   wb_rst_i  : asynchronous active-high reset
//   bus.slave : detector inputs (enable, strobe, flags, data) and FIFO full;
//               outputs fd_restart, rx_byte/rx_byte_we, rx_start/rx_end,
//               rx_status[3:0] (0 break/disable, 1 partial, 2 overflow,
//               3 overrun), rx_byte_cnt[11:0], rx_active.
module irda_fir_rx_ctrl #(
  parameter int PA_TIMEOUT = 512,
  parameter int MAX_BYTES  = 2050
) (
  input  logic              clk,
  input  logic              wb_rst_i,
  irda_fir_rx_ctrl_if.slave bus
);

  localparam logic [10:0] PA_LIM  = 11'(PA_TIMEOUT);
  localparam logic [11:0] MAX_CNT = 12'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, HUNT, PREAMBLE, DATA} state_t;

  state_t      state, state_n;
  logic [9:0]  pa_cnt, pa_cnt_n;
  logic [10:0] pa_inc;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shreg, shreg_n;

  logic        fd_restart_q, fd_restart_n;
  logic [7:0]  rx_byte_q, rx_byte_n;
  logic        we_q, we_n;
  logic        start_q, start_n;
  logic        end_q, end_n;
  logic [3:0]  status_q, status_n;
  logic [11:0] cnt_q, cnt_n;
  logic        active_q;

  logic        stb, term, restart_pulse;
  logic [3:0]  term_st;

  assign stb    = bus.fir_rx8_enable;
  assign pa_inc = {1'b0, pa_cnt} + 11'd1;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    pa_cnt_n      = pa_cnt;
    bit_cnt_n     = bit_cnt;
    shreg_n       = shreg;
    rx_byte_n     = rx_byte_q;
    we_n          = 1'b0;
    start_n       = 1'b0;
    end_n         = 1'b0;
    status_n      = status_q;
    cnt_n         = cnt_q;
    restart_pulse = 1'b0;
    term          = 1'b0;
    term_st       = 4'b0000;

    if (!bus.fir_rx_en) begin
      // Disable wins over everything; a frame in flight is closed as aborted.
      state_n = IDLE;
      if (state == DATA) begin
        end_n    = 1'b1;
        status_n = 4'b0001;
      end
    end else begin
      case (state)
        IDLE: state_n = HUNT;
        HUNT: begin
          if (stb && bus.pa_det) begin
            state_n  = PREAMBLE;
            pa_cnt_n = '0;
          end
        end
        PREAMBLE: begin
          if (stb) begin
            if (bus.break_det) begin
              state_n       = HUNT;
              restart_pulse = 1'b1;
            end else if (bus.sta_det) begin
              state_n   = DATA;
              start_n   = 1'b1;
              bit_cnt_n = '0;
              cnt_n     = '0;
              status_n  = '0;
            end else if (bus.pa_det) begin
              pa_cnt_n = '0;
            end else if (pa_inc >= PA_LIM) begin
              state_n       = HUNT;
              restart_pulse = 1'b1;
            end else begin
              pa_cnt_n = pa_inc[9:0];
            end
          end
        end
        DATA: begin
          if (stb) begin
            if (bus.break_det) begin
              term    = 1'b1;
              term_st = 4'b0001;
            end else if (bus.sto_det) begin
              term    = 1'b1;
              term_st = {2'b00, (bit_cnt != 3'd0), 1'b0};
            end else if (bus.fd_data_bit) begin
              shreg_n   = {bus.fd_o, shreg[7:1]};
              bit_cnt_n = bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (bus.rx_fifo_full) begin
                  term    = 1'b1;
                  term_st = 4'b1000;
                end else if (cnt_q == MAX_CNT) begin
                  term    = 1'b1;
                  term_st = 4'b0100;
                end else begin
                  we_n      = 1'b1;
                  rx_byte_n = shreg_n;
                  cnt_n     = cnt_q + 12'd1;
                end
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase

      if (term) begin
        state_n       = HUNT;
        end_n         = 1'b1;
        status_n      = term_st;
        restart_pulse = 1'b1;
      end
    end

    // Held while idle, otherwise a single-cycle pulse on leaving a frame.
    fd_restart_n = (state_n == IDLE) || restart_pulse;
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pa_cnt       <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      fd_restart_q <= 1'b1;
      rx_byte_q    <= '0;
      we_q         <= 1'b0;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      status_q     <= '0;
      cnt_q        <= '0;
      active_q     <= 1'b0;
    end else begin
      pa_cnt       <= pa_cnt_n;
      bit_cnt      <= bit_cnt_n;
      shreg        <= shreg_n;
      fd_restart_q <= fd_restart_n;
      rx_byte_q    <= rx_byte_n;
      we_q         <= we_n;
      start_q      <= start_n;
      end_q        <= end_n;
      status_q     <= status_n;
      cnt_q        <= cnt_n;
      active_q     <= (state_n == DATA);
    end
  end

  assign bus.fd_restart  = fd_restart_q;
  assign bus.rx_byte     = rx_byte_q;
  assign bus.rx_byte_we  = we_q;
  assign bus.rx_start    = start_q;
  assign bus.rx_end      = end_q;
  assign bus.rx_status   = status_q;
  assign bus.rx_byte_cnt = cnt_q;
  assign bus.rx_active   = active_q;

endmodule

// File: tb/tb_irda_fir_rx_ctrl.sv
// Scoreboard bench for irda_fir_rx_ctrl: frame-level stimulus pushes the
// expected event stream; a monitor pops and compares on DUT output events.
module tb_irda_fir_rx_ctrl;
  localparam int MAXB = 4;
  localparam int PATO = 32;
  localparam int K_START = 0, K_BYTE = 1, K_END = 2, K_RST = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic [3:0] st;
    int         cnt;
  } ev_t;

  logic clk = 1'b0;
  logic wb_rst_i = 1'b1;
  always #5 clk = ~clk;

  irda_fir_rx_ctrl_if bus();

  irda_fir_rx_ctrl #(.PA_TIMEOUT(PATO), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .bus(bus)
  );

  ev_t        exp_q[$];
  logic [7:0] fbytes[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic [3:0] s, input int c);
    ev_t e;
    e.kind = k; e.data = d; e.st = s; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic take(input int k, input logic [7:0] d, input logic [3:0] s, input int c);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: got kind %0d, expected no event", k);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k) begin
        n_errors++;
        $display("FAIL event_kind: got kind %0d, expected kind %0d", k, e.kind);
      end else if (k == K_BYTE && d !== e.data) begin
        n_errors++;
        $display("FAIL byte_data: got %02h, expected %02h", d, e.data);
      end else if (k == K_END && (s !== e.st || c != e.cnt)) begin
        n_errors++;
        $display("FAIL end_event: got status %b cnt %0d, expected status %b cnt %0d",
                 s, c, e.st, e.cnt);
      end
    end
  endtask

  // Monitor
  logic prev_fdr = 1'b1;
  logic pend = 1'b0;
  always @(negedge clk) begin
    if (!wb_rst_i) begin
      if (pend) chk("restart_one_cycle", bus.fd_restart, 1'b0);
      pend = 1'b0;
      if (bus.rx_start) begin
        take(K_START, 8'h0, 4'h0, 0);
        chk("active_at_start", bus.rx_active, 1'b1);
      end
      if (bus.rx_byte_we) take(K_BYTE, bus.rx_byte, 4'h0, 0);
      if (bus.rx_end) begin
        take(K_END, 8'h0, bus.rx_status, int'(bus.rx_byte_cnt));
        chk("restart_at_end", bus.fd_restart, 1'b1);
        chk("active_at_end", bus.rx_active, 1'b0);
      end
      if (bus.fd_restart && !prev_fdr && !bus.rx_end) take(K_RST, 8'h0, 4'h0, 0);
      if ((bus.rx_end || (bus.fd_restart && !prev_fdr)) && bus.fir_rx_en) pend = 1'b1;
    end else begin
      pend = 1'b0;
    end
    prev_fdr = bus.fd_restart;
  end

  // One bit strobe, then a gap with junk on the flag/data lines.
  task automatic strobe(input logic pa, input logic sta, input logic sto, input logic brk,
                        input logic db, input logic o, input logic full);
    logic [6:0] junk;
    @(posedge clk); #1;
    bus.pa_det = pa; bus.sta_det = sta; bus.sto_det = sto; bus.break_det = brk;
    bus.fd_data_bit = db; bus.fd_o = o; bus.rx_fifo_full = full;
    bus.fir_rx8_enable = 1'b1;
    @(posedge clk); #1;
    junk = 7'($urandom);
    {bus.pa_det, bus.sta_det, bus.sto_det, bus.break_det,
     bus.fd_data_bit, bus.fd_o, bus.rx_fifo_full} = junk;
    bus.fir_rx8_enable = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  // term: 0 stop flag, 1 break, 2 receiver disable
  task automatic send_frame(input int npre, input int extra, input int full_idx, input int term);
    logic [7:0] b;
    bit dead = 0;
    int n = fbytes.size();
    repeat (npre) strobe(1, 0, 0, 0, 0, 0, 0);
    push(K_START, 8'h0, 4'h0, 0);
    strobe(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < n && !dead; i++) begin
      b = fbytes[i];
      if (i == full_idx) begin push(K_END, 8'h0, 4'b1000, i); dead = 1; end
      else if (i >= MAXB) begin push(K_END, 8'h0, 4'b0100, MAXB); dead = 1; end
      else push(K_BYTE, b, 4'h0, 0);
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0) strobe(0, 0, 0, 0, 0, 0, 0);
        strobe(0, 0, 0, 0, 1, b[k], (k == 7 && i == full_idx) ? 1'b1 : 1'b0);
      end
    end
    if (!dead) begin
      for (int k = 0; k < extra; k++) strobe(0, 0, 0, 0, 1, 1'($urandom), 0);
      if (term == 0) begin
        push(K_END, 8'h0, (extra != 0) ? 4'b0010 : 4'b0000, n);
        strobe(0, 0, 1, 0, 0, 0, 0);
      end else if (term == 1) begin
        push(K_END, 8'h0, 4'b0001, n);
        strobe(0, 0, 0, 1, 0, 0, 0);
      end else begin
        push(K_END, 8'h0, 4'b0001, n);
        @(posedge clk); #1 bus.fir_rx_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("disable_idle_restart", bus.fd_restart, 1'b1);
        chk("disable_idle_active", bus.rx_active, 1'b0);
        bus.fir_rx_en = 1'b1;
      end
    end
    // Data after the frame closes must not produce writes.
    repeat (3) strobe(0, 0, 0, 0, 1, 1'($urandom), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fd_restart"}, bus.fd_restart, 1'b1);
    chk({tag, "_rx_byte"}, bus.rx_byte, 8'h00);
    chk({tag, "_rx_byte_we"}, bus.rx_byte_we, 1'b0);
    chk({tag, "_rx_start"}, bus.rx_start, 1'b0);
    chk({tag, "_rx_end"}, bus.rx_end, 1'b0);
    chk({tag, "_rx_status"}, bus.rx_status, 4'h0);
    chk({tag, "_rx_byte_cnt"}, bus.rx_byte_cnt, 12'h000);
    chk({tag, "_rx_active"}, bus.rx_active, 1'b0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, full_idx;
    bus.fir_rx_en = 0; bus.fir_rx8_enable = 0; bus.pa_det = 0; bus.sta_det = 0;
    bus.sto_det = 0; bus.break_det = 0; bus.fd_data_bit = 0; bus.fd_o = 0;
    bus.rx_fifo_full = 0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    wb_rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("idle_restart_held", bus.fd_restart, 1'b1);
    bus.fir_rx_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("hunt_restart_low", bus.fd_restart, 1'b0);

    // Normal frame
    fbytes = '{8'hA5, 8'h3C};
    send_frame(16, 0, -1, 0);
    chk("normal_cnt", bus.rx_byte_cnt, 12'd2);
    chk("normal_status", bus.rx_status, 4'b0000);
    chk("rx_byte_held", bus.rx_byte, 8'h3C);

    // Partial byte
    fbytes = '{8'h5A};
    send_frame(4, 4, -1, 0);
    chk("partial_cnt", bus.rx_byte_cnt, 12'd1);
    chk("partial_status", bus.rx_status, 4'b0010);

    // Break after 3 bytes
    fbytes = '{8'h11, 8'h22, 8'h33};
    send_frame(4, 0, -1, 1);
    chk("break_status", bus.rx_status, 4'b0001);
    chk("break_hunt", bus.rx_active, 1'b0);

    // FIFO full on second byte
    fbytes = '{8'hC3, 8'h7E, 8'h99};
    send_frame(4, 0, 1, 0);
    chk("full_status", bus.rx_status, 4'b1000);
    chk("full_cnt", bus.rx_byte_cnt, 12'd1);

    // Overflow: 5 bytes with MAX_BYTES=4
    fbytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(4, 0, -1, 0);
    chk("ovf_status", bus.rx_status, 4'b0100);
    chk("ovf_cnt", bus.rx_byte_cnt, 12'd4);

    // Preamble timeout
    repeat (8) strobe(1, 0, 0, 0, 0, 0, 0);
    repeat (PATO - 1) strobe(0, 0, 0, 0, 0, 0, 0);
    push(K_RST, 8'h0, 4'h0, 0);
    strobe(0, 0, 0, 0, 0, 0, 0);
    chk("timeout_no_active", bus.rx_active, 1'b0);

    // Break during preamble
    repeat (3) strobe(1, 0, 0, 0, 0, 0, 0);
    push(K_RST, 8'h0, 4'h0, 0);
    strobe(0, 1, 0, 1, 0, 0, 0);

    // Disable mid-frame
    fbytes = '{8'hE7, 8'h18};
    send_frame(4, 3, -1, 2);
    chk("disable_status", bus.rx_status, 4'b0001);

    // Reset mid-frame
    repeat (2) strobe(1, 0, 0, 0, 0, 0, 0);
    push(K_START, 8'h0, 4'h0, 0);
    strobe(0, 1, 0, 0, 0, 0, 0);
    push(K_BYTE, 8'h96, 4'h0, 0);
    for (int k = 0; k < 8; k++) strobe(0, 0, 0, 0, 1, k[0] ^ k[1] ^ k[2], 0);
    strobe(0, 0, 0, 0, 1, 1, 0);
    chk("pre_reset_active", bus.rx_active, 1'b1);
    @(posedge clk); #1 wb_rst_i = 1'b1;
    #1 chk_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1 wb_rst_i = 1'b0;

    // Random frames
    for (int f = 0; f < 20; f++) begin
      nb = $urandom_range(0, 6);
      fbytes.delete();
      for (int i = 0; i < nb; i++) fbytes.push_back(8'($urandom));
      full_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      send_frame($urandom_range(1, 8), $urandom_range(0, 7), full_idx, $urandom_range(0, 2));
    end

    repeat (5) @(posedge clk);
    #1 chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
